// File: rtl/enigma_pkg.sv
// Shared letter and lamp-FSM definitions for the Enigma lamp board datapath.
// Letters are 6-bit indices; only 0..25 (A..Z) name a lamp.
package enigma_pkg;

    localparam int LETTER_W    = 6;
    localparam int NUM_LETTERS = 26;

    typedef logic [LETTER_W-1:0] letter_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LIGHT = 2'd1,
        ST_GAP   = 2'd2
    } lamp_state_e;

    function automatic logic is_valid_letter(input letter_t l);
        return l < letter_t'(NUM_LETTERS);
    endfunction

endpackage

// File: rtl/letter_fifo.sv
// First-word-fall-through letter FIFO; head is visible the cycle after the push into an empty FIFO.
// Pushes while full and pops while empty are ignored; o_full/o_empty come straight from the occupancy register.
module letter_fifo
    import enigma_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  logic [LETTER_W-1:0] i_push_dat,
    input  logic                i_pop,
    output logic [LETTER_W-1:0] o_head_dat,
    output logic                o_full,
    output logic                o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    letter_t          r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == '0);
    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/lamp_driver.sv
// Lights one lamp per accepted letter for HOLD_CYCLES then dark for GAP_CYCLES; lamp appears one cycle after accept.
// in_ready is low while a lamp sequence runs or the readout FIFO is full; valid letters are logged in the FIFO.
module lamp_driver
    import enigma_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [LETTER_W-1:0]    in_letter,
    output logic                   in_ready,
    output logic [NUM_LETTERS-1:0] lamp,
    output logic                   lamp_busy,
    output logic                   err_invalid,
    output logic                   out_valid,
    output logic [LETTER_W-1:0]    out_letter,
    input  logic                   out_ready
);

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0]       HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       GAP_LD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_LETTERS-1:0] LAMP_ONE = NUM_LETTERS'(1);

    lamp_state_e      r_state;
    lamp_state_e      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    letter_t          r_letter;
    logic             r_live;
    logic             r_err;
    logic             w_xfer;
    logic             w_letter_ok;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    assign w_xfer      = in_valid & in_ready;
    assign w_letter_ok = is_valid_letter(in_letter);
    assign w_push      = w_xfer & w_letter_ok;
    assign w_pop       = out_valid & out_ready;

    // r_live keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_letter <= '0;
            r_live   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_live  <= 1'b1;
            r_err   <= w_xfer & ~w_letter_ok;
            if (w_push) r_letter <= in_letter;
            if (r_state == ST_IDLE && w_next_state == ST_LIGHT)
                r_cnt <= HOLD_LD;
            else if (r_state == ST_LIGHT && w_next_state == ST_GAP)
                r_cnt <= GAP_LD;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - CNT_ONE;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_push) w_next_state = ST_LIGHT;
            ST_LIGHT: if (r_cnt == '0) w_next_state = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (r_cnt == '0) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        lamp      = '0;
        lamp_busy = (r_state != ST_IDLE);
        in_ready  = r_live & (r_state == ST_IDLE) & ~w_full;
        if (r_state == ST_LIGHT) lamp = LAMP_ONE << r_letter;
    end

    assign err_invalid = r_err;
    assign out_valid   = ~w_empty;

    letter_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (in_letter),
        .i_pop      (w_pop),
        .o_head_dat (out_letter),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

endmodule

// File: tb/tb_lamp_driver.sv
// Bench for lamp_driver: instance A (HOLD=4, GAP=2) and instance B (HOLD=1, GAP=0) against a timing/queue reference model.
module tb_lamp_driver;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]       in_valid, in_ready, lamp_busy, err_invalid, out_valid, out_ready;
    logic [1:0][5:0]  in_letter, out_letter;
    logic [1:0][25:0] lamp;

    always #5 clk = ~clk;

    lamp_driver #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_letter(in_letter[0]), .in_ready(in_ready[0]),
        .lamp(lamp[0]), .lamp_busy(lamp_busy[0]), .err_invalid(err_invalid[0]),
        .out_valid(out_valid[0]), .out_letter(out_letter[0]), .out_ready(out_ready[0])
    );

    lamp_driver #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_letter(in_letter[1]), .in_ready(in_ready[1]),
        .lamp(lamp[1]), .lamp_busy(lamp_busy[1]), .err_invalid(err_invalid[1]),
        .out_valid(out_valid[1]), .out_letter(out_letter[1]), .out_ready(out_ready[1])
    );

    localparam int DEPTH = 8;
    int hold_c[2] = '{4, 1};
    int gap_c[2]  = '{2, 0};

    // Model: cycle count since reset release, cycle each lamp was first lit, and the letter log.
    int         cyc;
    int         acc[2];
    logic [5:0] lit[2];
    bit         err_m[2];
    bit         xfer_flag[2];
    logic [5:0] qa[$];
    logic [5:0] qb[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    function automatic logic [5:0] qhead(input int d);
        if (qsize(d) == 0) return 6'd0;
        return (d == 0) ? qa[0] : qb[0];
    endfunction

    function automatic bit m_busy(input int d);
        int age = cyc - acc[d];
        return (age >= 0) && (age < hold_c[d] + gap_c[d]);
    endfunction

    function automatic logic [25:0] m_lamp(input int d);
        int age = cyc - acc[d];
        logic [25:0] one = 26'd1;
        if (age >= 0 && age < hold_c[d]) return one << lit[d];
        return 26'd0;
    endfunction

    function automatic bit m_ready(input int d);
        return (cyc >= 1) && !m_busy(d) && (qsize(d) < DEPTH);
    endfunction

    task automatic m_reset();
        cyc   = 0;
        acc   = '{-1000, -1000};
        err_m = '{1'b0, 1'b0};
        qa.delete();
        qb.delete();
    endtask

    task automatic m_edge();
        for (int d = 0; d < 2; d++) begin
            bit x, p;
            x = in_valid[d] && m_ready(d);
            p = out_ready[d] && (qsize(d) > 0);
            xfer_flag[d] = x;
            err_m[d] = x && (in_letter[d] >= 6'd26);
            if (p) begin
                if (d == 0) void'(qa.pop_front());
                else        void'(qb.pop_front());
            end
            if (x && in_letter[d] < 6'd26) begin
                if (d == 0) qa.push_back(in_letter[d]);
                else        qb.push_back(in_letter[d]);
                acc[d] = cyc + 1;
                lit[d] = in_letter[d];
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            string p = (d == 0) ? "A" : "B";
            chk({p, "_lamp"},       32'(lamp[d]),        32'(m_lamp(d)));
            chk({p, "_busy"},       32'(lamp_busy[d]),   32'(m_busy(d)));
            chk({p, "_in_ready"},   32'(in_ready[d]),    32'(m_ready(d)));
            chk({p, "_err"},        32'(err_invalid[d]), 32'(err_m[d]));
            chk({p, "_out_valid"},  32'(out_valid[d]),   32'(qsize(d) > 0));
            chk({p, "_out_letter"}, 32'(out_letter[d]),  32'(qhead(d)));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    // Reset is asserted between edges so its asynchronous effect is checked 1 time unit later.
    task automatic apply_reset();
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic send(input int d, input logic [5:0] l, input bit pop);
        int guard = 0;
        while (!m_ready(d) && guard < 100) begin
            cycle();
            guard++;
        end
        chk("send_wait", 32'(guard < 100), 32'd1);
        in_valid[d]  = 1'b1;
        in_letter[d] = l;
        if (pop) out_ready[d] = 1'b1;
        cycle();
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
    endtask

    initial begin
        int t_acc, g, lit_n, k;
        logic [5:0] popped[$];
        int accs[$];

        in_valid  = '0;
        in_letter = '0;
        out_ready = '0;
        rst_n     = 1'b0;
        #2;
        apply_reset();
        cycle();
        chk("post_reset_in_ready", 32'(in_ready[0]), 32'd1);

        // Letter H: 4 lit cycles, 2 dark, ready again 7 cycles after the accept cycle.
        send(0, 6'd7, 1'b0);
        t_acc = cyc;
        lit_n = 0;
        g = 0;
        while (!in_ready[0] && g < 20) begin
            if (lamp[0] == 26'h80) lit_n++;
            cycle();
            g++;
        end
        chk("h_lamp_cycles", 32'(lit_n), 32'd4);
        chk("h_accept_to_ready", 32'(cyc - t_acc + 1), 32'd7);
        chk("h_out_letter", 32'(out_letter[0]), 32'd7);
        out_ready[0] = 1'b1;
        cycle();
        out_ready[0] = 1'b0;

        // Invalid index 30.
        send(0, 6'd30, 1'b0);
        chk("inv_err_pulse", 32'(err_invalid[0]), 32'd1);
        chk("inv_in_ready", 32'(in_ready[0]), 32'd1);
        chk("inv_lamp", 32'(lamp[0]), 32'd0);
        chk("inv_out_valid", 32'(out_valid[0]), 32'd0);
        cycle();
        chk("inv_err_one_cycle", 32'(err_invalid[0]), 32'd0);

        // Fill the FIFO with 0..7, ninth letter must wait for a pop.
        k = 0;
        g = 0;
        in_valid[0] = 1'b1;
        while (k < 8 && g < 200) begin
            in_letter[0] = 6'(k);
            cycle();
            if (xfer_flag[0]) k++;
            g++;
        end
        in_letter[0] = 6'd8;
        repeat (10) begin
            cycle();
            if (xfer_flag[0]) k++;
        end
        chk("fill_accepts", 32'(k), 32'd8);
        chk("fill_in_ready_low", 32'(in_ready[0]), 32'd0);
        popped.delete();
        out_ready[0] = 1'b1;
        g = 0;
        while (popped.size() < 9 && g < 60) begin
            if (out_valid[0]) popped.push_back(out_letter[0]);
            cycle();
            if (xfer_flag[0]) begin
                k++;
                in_valid[0] = 1'b0;
            end
            g++;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        chk("drain_count", 32'(popped.size()), 32'd9);
        for (int i = 0; i < popped.size(); i++) chk("drain_order", 32'(popped[i]), 32'(i));
        chk("ninth_accepted", 32'(k), 32'd9);

        // Three entries held, then push 25 with a pop on the same edge.
        send(0, 6'd10, 1'b0);
        send(0, 6'd11, 1'b0);
        send(0, 6'd12, 1'b0);
        send(0, 6'd25, 1'b1);
        popped.delete();
        out_ready[0] = 1'b1;
        g = 0;
        while (out_valid[0] && g < 20) begin
            popped.push_back(out_letter[0]);
            cycle();
            g++;
        end
        out_ready[0] = 1'b0;
        chk("pp_count", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            chk("pp_first", 32'(popped[0]), 32'd11);
            chk("pp_last", 32'(popped[2]), 32'd25);
        end

        // Reset in the middle of the lamp for E with a FIFO entry pending.
        send(0, 6'd4, 1'b0);
        cycle();
        chk("rst_pre_lamp", 32'(lamp[0]), 32'h10);
        apply_reset();
        cycle();
        chk("rst_release_in_ready", 32'(in_ready[0]), 32'd1);
        chk("rst_fifo_discarded", 32'(out_valid[0]), 32'd0);

        // HOLD=1, GAP=0 instance: continuous offers accepted every 2 cycles.
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        in_letter[1] = 6'd3;
        accs.delete();
        g = 0;
        while (accs.size() < 6 && g < 40) begin
            cycle();
            g++;
            if (xfer_flag[1]) begin
                accs.push_back(cyc);
                in_letter[1] = (in_letter[1] == 6'd3) ? 6'd17 : 6'd3;
            end
        end
        in_valid[1] = 1'b0;
        chk("b_accepts", 32'(accs.size()), 32'd6);
        for (int i = 1; i < accs.size(); i++) chk("b_spacing", 32'(accs[i] - accs[i-1]), 32'd2);
        repeat (4) cycle();
        out_ready[1] = 1'b0;

        // Random traffic on both instances, with one reset part way through.
        for (int n = 0; n < 800; n++) begin
            if (n == 400) apply_reset();
            for (int d = 0; d < 2; d++) begin
                in_valid[d]  = ($urandom_range(0, 2) != 0);
                in_letter[d] = ($urandom_range(0, 4) == 0) ? 6'(26 + $urandom_range(0, 37))
                                                           : 6'($urandom_range(0, 25));
                out_ready[d] = ($urandom_range(0, 3) == 0);
            end
            cycle();
        end
        in_valid  = '0;
        out_ready = '0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
